// File: rtl/amber48_pkg.sv
// Shared amber48 core types: datapath width, fetch slot/output records and the
// fetch-to-decode hand-off.
package amber48_pkg;

  localparam int XLEN                = 48;
  localparam int BAU_BYTES           = 6;
  localparam int FETCH_DEPTH_DEFAULT = 4;

  localparam logic [2:0] TRAP_FETCH_FAULT = 3'd1;

  typedef logic [XLEN-1:0] amber48_word_t;

  typedef struct packed {
    amber48_word_t pc;
    amber48_word_t instr;
    logic          fault;
    logic          filled;
  } amber48_fetch_slot_s;

  typedef struct packed {
    logic          valid;
    amber48_word_t pc;
    amber48_word_t instr;
    logic          fault;
  } amber48_fetch_out_s;

  typedef struct packed {
    logic          valid;
    amber48_word_t pc;
    amber48_word_t instr;
    logic          trap;
    logic [2:0]    trap_cause;
  } amber48_decode_in_s;

  // A faulting fetch reaches decode as a pre-flagged trap with the fetch cause.
  function automatic amber48_decode_in_s fetch_to_decode(input amber48_fetch_out_s f);
    amber48_decode_in_s d;
    d.valid      = f.valid;
    d.pc         = f.pc;
    d.instr      = f.instr;
    d.trap       = f.fault;
    d.trap_cause = f.fault ? TRAP_FETCH_FAULT : 3'd0;
    return d;
  endfunction

endpackage

// File: rtl/amber48_fetch_ring.sv
// Prefetch slot storage with alloc/fill/head pointers; each pointer carries a
// wrap bit so full and empty are distinguishable.
module amber48_fetch_ring
  import amber48_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic               alloc_i,
  input  logic [XLEN-1:0]    alloc_pc_i,
  input  logic               fill_i,
  input  logic [XLEN-1:0]    fill_instr_i,
  input  logic               fill_fault_i,
  input  logic               consume_i,
  output logic [PW-1:0]      used_o,
  output logic [PW-1:0]      inflight_o,
  output amber48_fetch_out_s head_o
);

  localparam int IW = PW - 1;

  amber48_fetch_slot_s slots_q [DEPTH];
  logic [PW-1:0]       alloc_q, fill_q, head_q;
  logic [IW-1:0]       alloc_idx, fill_idx, head_idx;

  assign alloc_idx = alloc_q[IW-1:0];
  assign fill_idx  = fill_q[IW-1:0];
  assign head_idx  = head_q[IW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        // Dropping everything between head and alloc empties the ring in place.
        head_q <= alloc_q;
        fill_q <= alloc_q;
      end else begin
        if (alloc_i) begin
          slots_q[alloc_idx].pc     <= alloc_pc_i;
          slots_q[alloc_idx].fault  <= 1'b0;
          slots_q[alloc_idx].filled <= 1'b0;
          alloc_q                   <= alloc_q + 1'b1;
        end
        if (fill_i) begin
          slots_q[fill_idx].instr  <= fill_instr_i;
          slots_q[fill_idx].fault  <= fill_fault_i;
          slots_q[fill_idx].filled <= 1'b1;
          fill_q                   <= fill_q + 1'b1;
        end
        if (consume_i) begin
          slots_q[head_idx].filled <= 1'b0;
          head_q                   <= head_q + 1'b1;
        end
      end
    end
  end

  assign used_o     = alloc_q - head_q;
  assign inflight_o = alloc_q - fill_q;

  assign head_o.valid = (head_q != fill_q) && slots_q[head_idx].filled;
  assign head_o.pc    = slots_q[head_idx].pc;
  assign head_o.instr = slots_q[head_idx].instr;
  assign head_o.fault = slots_q[head_idx].fault;

endmodule

// File: rtl/amber48_fetch_unit.sv
// amber48 instruction-fetch front end: multi-outstanding imem requests into a
// prefetch ring, redirect squashing and fault halting. Macro AMBER48_FETCH_STATS_EN adds counters.
module amber48_fetch_unit
  import amber48_pkg::*;
#(
  parameter int              DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter int              PC_STEP  = BAU_BYTES,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clk_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_valid_i,
  input  logic [XLEN-1:0] imem_data_i,
  input  logic            imem_err_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic [XLEN-1:0] fetch_instr_o,
  output logic            fetch_fault_o
`ifdef AMBER48_FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched_o,
  output logic [31:0]     stat_squashed_o
`endif
);

  localparam int            PW    = $clog2(DEPTH) + 1;
  localparam logic [PW:0]   SLOTS = (PW+1)'(DEPTH);

  logic [XLEN-1:0]    pc_q;
  logic [PW-1:0]      drop_cnt_q;
  logic               halt_q;
  logic [PW-1:0]      used, inflight;
  logic [PW:0]        occupancy;
  logic               accept, resp, drop, fill, consume;
  amber48_fetch_out_s head;

  // Squashed requests still hold a slot's worth of credit until their response returns.
  assign occupancy  = {1'b0, used} + {1'b0, drop_cnt_q};
  assign imem_req_o = rst_ni && clk_en_i && !redirect_i && !halt_q && (occupancy < SLOTS);
  assign imem_addr_o = pc_q;

  assign accept  = imem_req_o && imem_ready_i;
  assign resp    = clk_en_i && imem_valid_i;
  assign drop    = resp && (drop_cnt_q != '0);
  assign fill    = resp && (drop_cnt_q == '0) && !redirect_i;
  assign consume = clk_en_i && head.valid && fetch_ready_i && !redirect_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      halt_q     <= 1'b0;
    end else if (clk_en_i) begin
      if (redirect_i) begin
        pc_q       <= redirect_pc_i;
        drop_cnt_q <= drop_cnt_q + inflight - PW'(resp);
        halt_q     <= 1'b0;
      end else begin
        if (accept) pc_q <= pc_q + XLEN'(PC_STEP);
        if (drop) drop_cnt_q <= drop_cnt_q - 1'b1;
        if (fill && imem_err_i) halt_q <= 1'b1;
      end
    end
  end

  amber48_fetch_ring #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ring (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (clk_en_i),
    .flush_i      (redirect_i),
    .alloc_i      (accept),
    .alloc_pc_i   (pc_q),
    .fill_i       (fill),
    .fill_instr_i (imem_err_i ? '0 : imem_data_i),
    .fill_fault_i (imem_err_i),
    .consume_i    (consume),
    .used_o       (used),
    .inflight_o   (inflight),
    .head_o       (head)
  );

  assign fetch_valid_o = head.valid;
  assign fetch_pc_o    = head.pc;
  assign fetch_instr_o = head.instr;
  assign fetch_fault_o = head.fault;

`ifdef AMBER48_FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] fetched_q, squashed_q;

  // Any response not written into a slot counts as squashed, including one landing on a redirect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else if (clk_en_i) begin
      if (fill) fetched_q <= sat_inc(fetched_q);
      if (resp && !fill) squashed_q <= sat_inc(squashed_q);
    end
  end

  assign stat_fetched_o  = fetched_q;
  assign stat_squashed_o = squashed_q;
`endif

`ifndef SYNTHESIS
  resp_while_gated_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !clk_en_i |-> !imem_valid_i);
`endif

endmodule
